mips_bus_arbiter: RTL and testbench

- Two-master to one-slave arbiter for the CPU memory bus (Avalon-MM style: address/read/write/writedata/byteenable/readdata/waitrequest).
- Master 0 is the instruction-fetch port; master 1 is the load/store port. Both share the single RAM/slave interface.
- Round-robin grant with a registered owner FSM. Slave-side signals are muxed from the current owner; the slave's waitrequest is steered back to the owner.

---
 rtl/mips_bus_arbiter.sv | 172 +++++++++++++++++
 tb/tb_mips_bus_arbiter.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_bus_arbiter.sv
// Two-master round-robin arbiter for the CPU memory bus (m0 = fetch, m1 = load/store).
// Optional wait-cycle abort is compiled in with the ARB_TIMEOUT_EN macro.
module mips_bus_arbiter #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [ADDR_W-1:0]   m0_address,
   input  logic                m0_read,
   input  logic                m0_write,
   input  logic [DATA_W-1:0]   m0_writedata,
   input  logic [DATA_W/8-1:0] m0_byteenable,
   output logic                m0_waitrequest,
   input  logic [ADDR_W-1:0]   m1_address,
   input  logic                m1_read,
   input  logic                m1_write,
   input  logic [DATA_W-1:0]   m1_writedata,
   input  logic [DATA_W/8-1:0] m1_byteenable,
   output logic                m1_waitrequest,
   output logic [DATA_W-1:0]   m_readdata,
   output logic [ADDR_W-1:0]   s_address,
   output logic                s_read,
   output logic                s_write,
   output logic [DATA_W-1:0]   s_writedata,
   output logic [DATA_W/8-1:0] s_byteenable,
   input  logic                s_waitrequest,
   input  logic [DATA_W-1:0]   s_readdata,
   output logic [1:0]          grant,
   output logic                timeout_err
);

   localparam logic [DATA_W-1:0] AbortData = DATA_W'(32'hDEADBEEF);

   typedef enum logic [1:0] {
      StNone = 2'd0,
      StM0   = 2'd1,
      StM1   = 2'd2
   } owner_e;

   owner_e owner_q, owner_d;
   owner_e last_q, last_d;
   logic   req0, req1;
   logic   timeout_hit;

   assign req0 = m0_read | m0_write;
   assign req1 = m1_read | m1_write;

`ifdef ARB_TIMEOUT_EN
   localparam int unsigned CntW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

   logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
   logic            timeout_err_q;

   // Counter sits at zero while idle, so every fresh grant starts from zero.
   always_comb begin
      wait_cnt_d = wait_cnt_q;
      if (owner_q == StNone) begin
         wait_cnt_d = '0;
      end else if (s_waitrequest) begin
         wait_cnt_d = wait_cnt_q + CntW'(1);
      end
   end

   assign timeout_hit = (owner_q != StNone) && (wait_cnt_q == CntW'(TIMEOUT));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wait_cnt_q    <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         wait_cnt_q <= wait_cnt_d;
         if (timeout_hit) begin
            timeout_err_q <= 1'b1;
         end
      end
   end

   // Visible in the abort cycle itself, then held until reset.
   assign timeout_err = timeout_err_q | timeout_hit;
`else
   assign timeout_hit = 1'b0;
   assign timeout_err = 1'b0;
`endif

   always_comb begin
      owner_d        = owner_q;
      last_d         = last_q;
      grant          = 2'b00;
      s_address      = '0;
      s_read         = 1'b0;
      s_write        = 1'b0;
      s_writedata    = '0;
      s_byteenable   = '0;
      m0_waitrequest = 1'b1;
      m1_waitrequest = 1'b1;
      m_readdata     = s_readdata;

      unique case (owner_q)
         StNone: begin
            if (req0 && req1) begin
               owner_d = (last_q == StM0) ? StM1 : StM0;
            end else if (req0) begin
               owner_d = StM0;
            end else if (req1) begin
               owner_d = StM1;
            end
         end
         StM0: begin
            grant          = 2'b01;
            s_address      = m0_address;
            s_write        = m0_write;
            s_read         = m0_read & ~m0_write;
            s_writedata    = m0_writedata;
            s_byteenable   = m0_byteenable;
            m0_waitrequest = s_waitrequest;
            // A dropped request abandons the slot without counting as service.
            if (!req0) begin
               owner_d = StNone;
            end else if (!s_waitrequest) begin
               owner_d = StNone;
               last_d  = StM0;
            end
         end
         StM1: begin
            grant          = 2'b10;
            s_address      = m1_address;
            s_write        = m1_write;
            s_read         = m1_read & ~m1_write;
            s_writedata    = m1_writedata;
            s_byteenable   = m1_byteenable;
            m1_waitrequest = s_waitrequest;
            if (!req1) begin
               owner_d = StNone;
            end else if (!s_waitrequest) begin
               owner_d = StNone;
               last_d  = StM1;
            end
         end
         default: begin
            owner_d = StNone;
         end
      endcase

      // Abort: release the owner with poison data and no slave strobe.
      if (timeout_hit) begin
         s_read     = 1'b0;
         s_write    = 1'b0;
         m_readdata = AbortData;
         owner_d    = StNone;
         last_d     = owner_q;
         if (owner_q == StM0) begin
            m0_waitrequest = 1'b0;
         end
         if (owner_q == StM1) begin
            m1_waitrequest = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         owner_q <= StNone;
         last_q  <= StM1;
      end else begin
         owner_q <= owner_d;
         last_q  <= last_d;
      end
   end

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Bench for mips_bus_arbiter: directed vector table, multi-cycle sequences and a
// randomized run against a rule-level reference model.
module tb_mips_bus_arbiter;

   localparam int Timeout = 4;
`ifdef ARB_TIMEOUT_EN
   localparam bit ToEn = 1'b1;
`else
   localparam bit ToEn = 1'b0;
`endif
   localparam logic Y = 1'b1;
   localparam logic N = 1'b0;
   localparam logic [31:0] M0Wd = 32'h1111_1111;
   localparam logic [3:0]  M0Be = 4'hF;

   logic        clk;
   logic        reset;
   logic [31:0] m0_address, m1_address, m0_writedata, m1_writedata;
   logic        m0_read, m0_write, m1_read, m1_write;
   logic [3:0]  m0_byteenable, m1_byteenable;
   logic        m0_waitrequest, m1_waitrequest;
   logic [31:0] m_readdata, s_address, s_writedata, s_readdata;
   logic        s_read, s_write, s_waitrequest;
   logic [3:0]  s_byteenable;
   logic [1:0]  grant;
   logic        timeout_err;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model state: owner index (-1 idle), last served, wait count, sticky error.
   int   mown, mlast, mcnt;
   logic merr;

   mips_bus_arbiter #(
      .ADDR_W (32),
      .DATA_W (32),
      .TIMEOUT(Timeout)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .m0_address    (m0_address),
      .m0_read       (m0_read),
      .m0_write      (m0_write),
      .m0_writedata  (m0_writedata),
      .m0_byteenable (m0_byteenable),
      .m0_waitrequest(m0_waitrequest),
      .m1_address    (m1_address),
      .m1_read       (m1_read),
      .m1_write      (m1_write),
      .m1_writedata  (m1_writedata),
      .m1_byteenable (m1_byteenable),
      .m1_waitrequest(m1_waitrequest),
      .m_readdata    (m_readdata),
      .s_address     (s_address),
      .s_read        (s_read),
      .s_write       (s_write),
      .s_writedata   (s_writedata),
      .s_byteenable  (s_byteenable),
      .s_waitrequest (s_waitrequest),
      .s_readdata    (s_readdata),
      .grant         (grant),
      .timeout_err   (timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic m0_rd, m0_wr; logic [31:0] m0_addr;
      logic m1_rd, m1_wr; logic [31:0] m1_addr, m1_wd; logic [3:0] m1_be;
      logic sw; logic [31:0] srd;
      logic [1:0] e_grant; logic e_rd, e_wr; logic [31:0] e_addr, e_wd; logic [3:0] e_be;
      logic e_w0, e_w1;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      else n_pass++;
   endtask

   task automatic idle_inputs();
      m0_read = N; m0_write = N; m0_address = '0; m0_writedata = M0Wd; m0_byteenable = M0Be;
      m1_read = N; m1_write = N; m1_address = '0; m1_writedata = '0; m1_byteenable = '0;
      s_waitrequest = N; s_readdata = '0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      idle_inputs();
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      mown = -1; mlast = 1; mcnt = 0; merr = 1'b0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Expected outputs derived from the arbitration rules and the model state.
   task automatic check_model();
      logic rd [2], wr [2], ew [2];
      logic [31:0] ad [2], wd [2];
      logic [3:0]  be [2];
      logic [1:0]  eg;
      logic hit, owned;
      int   o;
      rd[0] = m0_read;    rd[1] = m1_read;
      wr[0] = m0_write;   wr[1] = m1_write;
      ad[0] = m0_address; ad[1] = m1_address;
      wd[0] = m0_writedata;  wd[1] = m1_writedata;
      be[0] = m0_byteenable; be[1] = m1_byteenable;
      owned = (mown >= 0);
      o     = owned ? mown : 0;
      hit   = ToEn && owned && (mcnt == Timeout);
      eg    = 2'b00;
      if (owned) eg[o] = 1'b1;
      for (int i = 0; i < 2; i++) ew[i] = !(owned && (o == i) && (!s_waitrequest || hit));
      chk("rnd_grant", {30'd0, grant}, {30'd0, eg});
      chk("rnd_s_read", {31'd0, s_read}, {31'd0, owned && rd[o] && !wr[o] && !hit});
      chk("rnd_s_write", {31'd0, s_write}, {31'd0, owned && wr[o] && !hit});
      chk("rnd_s_address", s_address, owned ? ad[o] : 32'd0);
      chk("rnd_s_writedata", s_writedata, owned ? wd[o] : 32'd0);
      chk("rnd_s_byteenable", {28'd0, s_byteenable}, {28'd0, owned ? be[o] : 4'd0});
      chk("rnd_m0_wait", {31'd0, m0_waitrequest}, {31'd0, ew[0]});
      chk("rnd_m1_wait", {31'd0, m1_waitrequest}, {31'd0, ew[1]});
      chk("rnd_readdata", m_readdata, hit ? 32'hDEADBEEF : s_readdata);
      chk("rnd_timeout_err", {31'd0, timeout_err}, {31'd0, merr || hit});
   endtask

   task automatic advance_model();
      logic req [2];
      req[0] = m0_read | m0_write;
      req[1] = m1_read | m1_write;
      if (mown < 0) begin
         mcnt = 0;
         if (req[0] && req[1]) mown = 1 - mlast;
         else if (req[0]) mown = 0;
         else if (req[1]) mown = 1;
      end else if (ToEn && mcnt == Timeout) begin
         merr = 1'b1; mlast = mown; mown = -1;
      end else if (!req[mown]) begin
         mown = -1;
      end else if (!s_waitrequest) begin
         mlast = mown; mown = -1;
      end else begin
         mcnt++;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      vec_t vecs [19];
      int c0, c1, nxt, order_err;

      vecs[0]  = '{Y,N,32'h100, N,Y,32'h200,32'hCAFEF00D,4'h3, N,32'h0,
                   2'b00,N,N,32'h0,32'h0,4'h0,Y,Y};
      vecs[1]  = '{Y,N,32'h100, N,Y,32'h200,32'hCAFEF00D,4'h3, N,32'h0,
                   2'b01,Y,N,32'h100,M0Wd,M0Be,N,Y};
      vecs[2]  = '{N,N,32'h100, N,Y,32'h200,32'hCAFEF00D,4'h3, N,32'h0,
                   2'b00,N,N,32'h0,32'h0,4'h0,Y,Y};
      vecs[3]  = '{N,N,32'h100, N,Y,32'h200,32'hCAFEF00D,4'h3, N,32'h0,
                   2'b10,N,Y,32'h200,32'hCAFEF00D,4'h3,Y,N};
      vecs[4]  = '{N,N,32'h100, N,N,32'h200,32'hCAFEF00D,4'h3, N,32'h0,
                   2'b00,N,N,32'h0,32'h0,4'h0,Y,Y};
      vecs[5]  = '{Y,N,32'h10, N,N,32'h0,32'h0,4'h0, N,32'h12345678,
                   2'b00,N,N,32'h0,32'h0,4'h0,Y,Y};
      vecs[6]  = '{Y,N,32'h10, N,N,32'h0,32'h0,4'h0, N,32'h12345678,
                   2'b01,Y,N,32'h10,M0Wd,M0Be,N,Y};
      vecs[7]  = '{N,N,32'h10, N,N,32'h0,32'h0,4'h0, N,32'h12345678,
                   2'b00,N,N,32'h0,32'h0,4'h0,Y,Y};
      vecs[8]  = '{N,N,32'h0, Y,Y,32'h300,32'hA5A5A5A5,4'hF, N,32'h0,
                   2'b00,N,N,32'h0,32'h0,4'h0,Y,Y};
      vecs[9]  = '{N,N,32'h0, Y,Y,32'h300,32'hA5A5A5A5,4'hF, N,32'h0,
                   2'b10,N,Y,32'h300,32'hA5A5A5A5,4'hF,Y,N};
      vecs[10] = '{N,N,32'h0, N,N,32'h300,32'hA5A5A5A5,4'hF, N,32'h0,
                   2'b00,N,N,32'h0,32'h0,4'h0,Y,Y};
      vecs[11] = '{Y,N,32'h40, N,N,32'h0,32'h0,4'h0, Y,32'h0,
                   2'b00,N,N,32'h0,32'h0,4'h0,Y,Y};
      vecs[12] = '{Y,N,32'h40, N,N,32'h0,32'h0,4'h0, Y,32'h0,
                   2'b01,Y,N,32'h40,M0Wd,M0Be,Y,Y};
      vecs[13] = '{N,N,32'h40, N,N,32'h0,32'h0,4'h0, Y,32'h0,
                   2'b01,N,N,32'h40,M0Wd,M0Be,Y,Y};
      vecs[14] = '{Y,N,32'h44, Y,N,32'h500,32'h0,4'h0, N,32'h0,
                   2'b00,N,N,32'h0,32'h0,4'h0,Y,Y};
      vecs[15] = '{Y,N,32'h44, Y,N,32'h500,32'h0,4'h0, N,32'h0,
                   2'b01,Y,N,32'h44,M0Wd,M0Be,N,Y};
      vecs[16] = '{N,N,32'h44, Y,N,32'h500,32'h0,4'h0, N,32'h0,
                   2'b00,N,N,32'h0,32'h0,4'h0,Y,Y};
      vecs[17] = '{N,N,32'h44, Y,N,32'h500,32'h0,4'h0, N,32'h0,
                   2'b10,Y,N,32'h500,32'h0,4'h0,Y,N};
      vecs[18] = '{N,N,32'h0, N,N,32'h0,32'h0,4'h0, N,32'h0,
                   2'b00,N,N,32'h0,32'h0,4'h0,Y,Y};

      // Reset state with requests already pending.
      reset = 1'b1;
      idle_inputs();
      m0_read = Y; m0_address = 32'h55; m1_write = Y; m1_address = 32'h66;
      @(posedge clk);
      #1;
      chk("reset_grant", {30'd0, grant}, 32'd0);
      chk("reset_s_read", {31'd0, s_read}, 32'd0);
      chk("reset_s_write", {31'd0, s_write}, 32'd0);
      chk("reset_s_address", s_address, 32'd0);
      chk("reset_s_writedata", s_writedata, 32'd0);
      chk("reset_s_byteenable", {28'd0, s_byteenable}, 32'd0);
      chk("reset_m0_wait", {31'd0, m0_waitrequest}, 32'd1);
      chk("reset_m1_wait", {31'd0, m1_waitrequest}, 32'd1);
      chk("reset_timeout_err", {31'd0, timeout_err}, 32'd0);

      do_reset();
      for (int i = 0; i < 19; i++) begin
         m0_read = vecs[i].m0_rd; m0_write = vecs[i].m0_wr; m0_address = vecs[i].m0_addr;
         m1_read = vecs[i].m1_rd; m1_write = vecs[i].m1_wr; m1_address = vecs[i].m1_addr;
         m1_writedata = vecs[i].m1_wd; m1_byteenable = vecs[i].m1_be;
         s_waitrequest = vecs[i].sw; s_readdata = vecs[i].srd;
         #1;
         chk($sformatf("vec%0d_grant", i), {30'd0, grant}, {30'd0, vecs[i].e_grant});
         chk($sformatf("vec%0d_s_read", i), {31'd0, s_read}, {31'd0, vecs[i].e_rd});
         chk($sformatf("vec%0d_s_write", i), {31'd0, s_write}, {31'd0, vecs[i].e_wr});
         chk($sformatf("vec%0d_s_address", i), s_address, vecs[i].e_addr);
         chk($sformatf("vec%0d_s_writedata", i), s_writedata, vecs[i].e_wd);
         chk($sformatf("vec%0d_s_be", i), {28'd0, s_byteenable}, {28'd0, vecs[i].e_be});
         chk($sformatf("vec%0d_m0_wait", i), {31'd0, m0_waitrequest}, {31'd0, vecs[i].e_w0});
         chk($sformatf("vec%0d_m1_wait", i), {31'd0, m1_waitrequest}, {31'd0, vecs[i].e_w1});
         chk($sformatf("vec%0d_readdata", i), m_readdata, vecs[i].srd);
         next_cycle();
      end

      // Fairness: both masters always requesting, zero-wait slave.
      do_reset();
      m0_read = Y; m0_address = 32'h1000; m1_read = Y; m1_address = 32'h2000;
      c0 = 0; c1 = 0; nxt = 0; order_err = 0;
      for (int cyc = 0; cyc < 20; cyc++) begin
         #1;
         if (!m0_waitrequest) begin
            c0++;
            if (nxt != 0) order_err++;
            nxt = 1;
         end
         if (!m1_waitrequest) begin
            c1++;
            if (nxt != 1) order_err++;
            nxt = 0;
         end
         next_cycle();
      end
      chk("fair_m0_count", 32'(c0), 32'd5);
      chk("fair_m1_count", 32'(c1), 32'd5);
      chk("fair_order_errors", 32'(order_err), 32'd0);
      m0_read = N; m1_read = N;
      next_cycle();

      // m1 write stalled three owned cycles; m0 requests meanwhile but must wait.
      m1_write = Y; m1_address = 32'h600; m1_writedata = 32'hBEEF0001; m1_byteenable = 4'hC;
      #1;
      chk("ws_idle_grant", {30'd0, grant}, 32'd0);
      next_cycle();
      for (int k = 1; k <= 4; k++) begin
         m0_read = Y; m0_address = 32'h700;
         s_waitrequest = (k < 4);
         #1;
         chk($sformatf("ws%0d_grant", k), {30'd0, grant}, 32'd2);
         chk($sformatf("ws%0d_s_write", k), {31'd0, s_write}, 32'd1);
         chk($sformatf("ws%0d_s_address", k), s_address, 32'h600);
         chk($sformatf("ws%0d_s_writedata", k), s_writedata, 32'hBEEF0001);
         chk($sformatf("ws%0d_m1_wait", k), {31'd0, m1_waitrequest}, (k == 4) ? 32'd0 : 32'd1);
         chk($sformatf("ws%0d_m0_wait", k), {31'd0, m0_waitrequest}, 32'd1);
         next_cycle();
      end
      m1_write = N; s_waitrequest = N;
      #1;
      chk("ws_gap_grant", {30'd0, grant}, 32'd0);
      next_cycle();
      chk("ws_m0_grant", {30'd0, grant}, 32'd1);
      chk("ws_m0_accept", {31'd0, m0_waitrequest}, 32'd0);
      next_cycle();
      m0_read = N;
      next_cycle();

      // Asynchronous reset while m1 owns a stalled write.
      m1_write = Y; m1_address = 32'h800; s_waitrequest = Y;
      #1;
      chk("ar_idle_grant", {30'd0, grant}, 32'd0);
      next_cycle();
      chk("ar_owned_grant", {30'd0, grant}, 32'd2);
      chk("ar_owned_s_write", {31'd0, s_write}, 32'd1);
      #2;
      reset = 1'b1;
      #1;
      chk("ar_s_write_drop", {31'd0, s_write}, 32'd0);
      chk("ar_grant_drop", {30'd0, grant}, 32'd0);
      chk("ar_s_address_drop", s_address, 32'd0);
      chk("ar_m1_wait", {31'd0, m1_waitrequest}, 32'd1);
      m1_write = N; s_waitrequest = N; m0_read = Y; m0_address = 32'h900;
      next_cycle();
      chk("ar_held_grant", {30'd0, grant}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      next_cycle();
      chk("ar_release_grant", {30'd0, grant}, 32'd1);
      chk("ar_release_s_read", {31'd0, s_read}, 32'd1);
      chk("ar_release_accept", {31'd0, m0_waitrequest}, 32'd0);
      next_cycle();
      m0_read = N;

      // Randomized traffic against the reference model.
      do_reset();
      for (int cyc = 0; cyc < 400; cyc++) begin
         if ($urandom_range(0, 3) == 0) begin
            m0_read = 1'($urandom_range(0, 1)); m0_write = ($urandom_range(0, 2) == 0);
            m0_address = $urandom; m0_writedata = $urandom; m0_byteenable = 4'($urandom);
         end
         if ($urandom_range(0, 3) == 0) begin
            m1_read = 1'($urandom_range(0, 1)); m1_write = ($urandom_range(0, 2) == 0);
            m1_address = $urandom; m1_writedata = $urandom; m1_byteenable = 4'($urandom);
         end
         s_waitrequest = ($urandom_range(0, 2) == 0);
         s_readdata = $urandom;
         #1;
         check_model();
         advance_model();
         next_cycle();
      end

`ifdef ARB_TIMEOUT_EN
      // Stuck slave on an m0 read is aborted after Timeout wait cycles.
      do_reset();
      m0_read = Y; m0_address = 32'h80; s_waitrequest = Y; s_readdata = 32'h0BAD0BAD;
      next_cycle();
      for (int k = 1; k <= Timeout; k++) begin
         #1;
         chk($sformatf("to%0d_m0_wait", k), {31'd0, m0_waitrequest}, 32'd1);
         chk($sformatf("to%0d_err", k), {31'd0, timeout_err}, 32'd0);
         next_cycle();
      end
      chk("to_abort_m0_wait", {31'd0, m0_waitrequest}, 32'd0);
      chk("to_abort_readdata", m_readdata, 32'hDEADBEEF);
      chk("to_abort_s_read", {31'd0, s_read}, 32'd0);
      chk("to_abort_err", {31'd0, timeout_err}, 32'd1);
      next_cycle();
      m0_read = N;
      #1;
      chk("to_after_grant", {30'd0, grant}, 32'd0);
      chk("to_after_err", {31'd0, timeout_err}, 32'd1);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
